// File: rtl/cp0_if.sv
// Bus bundle between the pipeline and the CP0 register file: WB write port,
// MFC0 read port, exception/ERET commit and the register value outputs.
interface cp0_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        input  rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o,
               timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        output rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o,
               timer_int_o
    );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC, BadVAddr with
// exception/ERET commit and a write-bypassed combinational MFC0 read port.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          COUNT_DIV  = 2
) (
    input logic   clk,
    input logic   rst,
    cp0_if.slave  bus
);
    localparam logic [4:0]  A_BADVADDR   = 5'd8;
    localparam logic [4:0]  A_COUNT      = 5'd9;
    localparam logic [4:0]  A_COMPARE    = 5'd11;
    localparam logic [4:0]  A_STATUS     = 5'd12;
    localparam logic [4:0]  A_CAUSE      = 5'd13;
    localparam logic [4:0]  A_EPC        = 5'd14;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        timer_q, timer_d, tick_q, tick_d, bd_q, bd_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;

    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, step;
    logic [31:0] cause_cur, rd_stored, rdata;

    function automatic logic [31:0] merge_status(input logic [31:0] cur, input logic [31:0] wd);
        return (cur & ~STATUS_WMASK) | (wd & STATUS_WMASK);
    endfunction

    assign wr_count   = bus.we_i && (bus.waddr_i == A_COUNT);
    assign wr_compare = bus.we_i && (bus.waddr_i == A_COMPARE);
    assign wr_status  = bus.we_i && (bus.waddr_i == A_STATUS);
    assign wr_cause   = bus.we_i && (bus.waddr_i == A_CAUSE);
    assign wr_epc     = bus.we_i && (bus.waddr_i == A_EPC);
    assign step       = (COUNT_DIV == 1) ? 1'b1 : tick_q;
    assign cause_cur  = {bd_q, timer_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

    always_comb begin
        tick_d     = (COUNT_DIV == 1) ? 1'b0 : ~tick_q;
        count_d    = count_q;
        compare_d  = compare_q;
        timer_d    = timer_q;
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_hw_d    = {bus.int_i[5] | timer_q, bus.int_i[4:0]};
        ip_sw_d    = ip_sw_q;

        if (wr_count)
            count_d = bus.wdata_i;
        else if (step)
            count_d = count_q + 32'd1;

        // Compare match uses the pre-increment Count; a Compare write clears and wins.
        if ((compare_q != 32'd0) && (count_q == compare_q))
            timer_d = 1'b1;
        if (wr_compare) begin
            compare_d = bus.wdata_i;
            timer_d   = 1'b0;
        end

        if (wr_status) status_d = merge_status(status_q, bus.wdata_i);
        if (wr_cause)  ip_sw_d  = bus.wdata_i[9:8];
        if (wr_epc)    epc_d    = bus.wdata_i;

        // Commit-side updates are applied last so they override the WB write per field.
        if (bus.exc_valid_i) begin
            status_d[1] = 1'b1;
            exccode_d   = bus.exc_code_i;
            if (!status_q[1]) begin
                epc_d = bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                bd_d  = bus.exc_bd_i;
            end
            if ((bus.exc_code_i == 5'd4) || (bus.exc_code_i == 5'd5))
                badvaddr_d = bus.exc_badvaddr_i;
        end else if (bus.eret_i) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= 1'b0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            timer_q    <= 1'b0;
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
        end else begin
            tick_q     <= tick_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
        end
    end

    always_comb begin
        case (bus.raddr_i)
            A_BADVADDR: rd_stored = badvaddr_q;
            A_COUNT:    rd_stored = count_q;
            A_COMPARE:  rd_stored = compare_q;
            A_STATUS:   rd_stored = status_q;
            A_CAUSE:    rd_stored = cause_cur;
            A_EPC:      rd_stored = epc_q;
            default:    rd_stored = 32'd0;
        endcase
        rdata = rd_stored;
        // BadVAddr and unmapped addresses are not writable, so they never bypass.
        if (bus.we_i && (bus.waddr_i == bus.raddr_i)) begin
            case (bus.waddr_i)
                A_COUNT, A_COMPARE, A_EPC: rdata = bus.wdata_i;
                A_STATUS: rdata = merge_status(status_q, bus.wdata_i);
                A_CAUSE:  rdata = {cause_cur[31:10], bus.wdata_i[9:8], cause_cur[7:0]};
                default:  rdata = rd_stored;
            endcase
        end
    end

    assign bus.rdata_o     = rdata;
    assign bus.count_o     = count_q;
    assign bus.compare_o   = compare_q;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_cur;
    assign bus.epc_o       = epc_q;
    assign bus.badvaddr_o  = badvaddr_q;
    assign bus.timer_int_o = timer_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: a read/write vector table plus hand-written
// sequences for timer, exception, ERET, wrap and asynchronous reset.
module tb_cp0_regfile;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cp0_if bus();

    cp0_regfile #(.STATUS_RST(32'h0040_0000), .COUNT_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},    bus.count_o,    32'd0);
        check({tag, "_compare"},  bus.compare_o,  32'd0);
        check({tag, "_status"},   bus.status_o,   32'h0040_0000);
        check({tag, "_cause"},    bus.cause_o,    32'd0);
        check({tag, "_epc"},      bus.epc_o,      32'd0);
        check({tag, "_badvaddr"}, bus.badvaddr_o, 32'd0);
        check({tag, "_timer"},    {31'd0, bus.timer_int_o}, 32'd0);
    endtask

    initial begin
        logic found;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.wdata_i = 32'd0; bus.raddr_i = 5'd12;
        bus.int_i = 6'd0; bus.exc_valid_i = 1'b0; bus.exc_code_i = 5'd0;
        bus.exc_pc_i = 32'd0; bus.exc_bd_i = 1'b0; bus.exc_badvaddr_i = 32'd0; bus.eret_i = 1'b0;

        vecs[0]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        vecs[1]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd12, 32'h0040_FF03};
        vecs[2]  = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[3]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0000_0300};
        vecs[4]  = '{1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
        vecs[5]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd14, 32'h1234_5678};
        vecs[6]  = '{1'b1, 5'd8,  32'h0000_DEAD, 5'd8,  32'h0000_0000};
        vecs[7]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd8,  32'h0000_0000};
        vecs[8]  = '{1'b1, 5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        vecs[9]  = '{1'b1, 5'd11, 32'h0000_0055, 5'd11, 32'h0000_0055};
        vecs[10] = '{1'b0, 5'd0,  32'h0000_0000, 5'd11, 32'h0000_0055};
        vecs[11] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd14, 32'h1234_5678};
        vecs[12] = '{1'b1, 5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000};
        vecs[13] = '{1'b0, 5'd0,  32'h0000_0000, 5'd12, 32'h0040_0000};
        vecs[14] = '{1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        vecs[15] = '{1'b0, 5'd0,  32'h0000_0000, 5'd13, 32'h0000_0000};

        // Reset held across edges, then 10 idle clocks: Count steps every 2nd clock
        step_clk();
        step_clk();
        check_reset_state("rst_hold");
        check("rst_rdata", bus.rdata_o, 32'h0040_0000);
        rst = 1'b0;
        repeat (10) step_clk();
        check("idle_count5", bus.count_o, 32'd5);
        check("idle_status", bus.status_o, 32'h0040_0000);
        check("idle_cause", bus.cause_o, 32'd0);

        // Timer: Count=0, Compare=20, wait for the match
        bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'd0;
        step_clk();
        bus.waddr_i = 5'd11; bus.wdata_i = 32'd20;
        step_clk();
        bus.we_i = 1'b0;
        check("timer_clear_before", {31'd0, bus.timer_int_o}, 32'd0);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.timer_int_o) begin
                found = 1'b1;
                break;
            end
            step_clk();
        end
        check("timer_found", {31'd0, found}, 32'd1);
        check("timer_count", bus.count_o, 32'd20);
        check("timer_ti", {31'd0, bus.cause_o[30]}, 32'd1);
        step_clk();
        check("timer_sticky", {31'd0, bus.timer_int_o}, 32'd1);
        check("timer_ip7", {31'd0, bus.cause_o[15]}, 32'd1);
        bus.we_i = 1'b1; bus.waddr_i = 5'd11; bus.wdata_i = 32'd100;
        step_clk();
        bus.we_i = 1'b0;
        check("timer_cleared", {31'd0, bus.timer_int_o}, 32'd0);
        bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'd100;
        step_clk();
        check("match_setup", bus.count_o, 32'd100);
        bus.waddr_i = 5'd11; bus.wdata_i = 32'd7;
        step_clk();
        bus.we_i = 1'b0;
        check("match_vs_clear", {31'd0, bus.timer_int_o}, 32'd0);
        step_clk();
        check("match_vs_clear2", {31'd0, bus.timer_int_o}, 32'd0);
        repeat (3) step_clk();

        // Table: write/read with bypass and writable-bit merge
        for (int i = 0; i < 16; i++) begin
            bus.we_i = vecs[i].we; bus.waddr_i = vecs[i].waddr;
            bus.wdata_i = vecs[i].wdata; bus.raddr_i = vecs[i].raddr;
            #1;
            check($sformatf("vec%0d_rdata", i), bus.rdata_o, vecs[i].exp);
            step_clk();
            bus.we_i = 1'b0;
        end

        // Exception in delay slot with AdEL
        bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd4; bus.exc_pc_i = 32'hBFC0_0100;
        bus.exc_bd_i = 1'b1; bus.exc_badvaddr_i = 32'h1234_5671;
        step_clk();
        check("exc1_epc", bus.epc_o, 32'hBFC0_00FC);
        check("exc1_cause", bus.cause_o, 32'h8000_0010);
        check("exc1_status", bus.status_o, 32'h0040_0002);
        check("exc1_badvaddr", bus.badvaddr_o, 32'h1234_5671);
        // Nested exception while EXL=1, also racing a WB write of EXL=0 with IM bits
        bus.exc_code_i = 5'd8; bus.exc_pc_i = 32'h8000_0000; bus.exc_bd_i = 1'b0;
        bus.exc_badvaddr_i = 32'hAAAA_AAAA;
        bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'h0000_0100;
        step_clk();
        bus.exc_valid_i = 1'b0; bus.we_i = 1'b0;
        check("exc2_epc", bus.epc_o, 32'hBFC0_00FC);
        check("exc2_cause", bus.cause_o, 32'h8000_0020);
        check("exc2_badvaddr", bus.badvaddr_o, 32'h1234_5671);
        check("exc2_status", bus.status_o, 32'h0040_0102);

        // ERET with WB Status=1, then ERET racing an exception
        bus.eret_i = 1'b1; bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'h0000_0001;
        step_clk();
        bus.we_i = 1'b0;
        check("eret_status", bus.status_o, 32'h0040_0001);
        bus.exc_valid_i = 1'b1; bus.exc_code_i = 5'd0; bus.exc_pc_i = 32'h0000_0100;
        bus.exc_bd_i = 1'b0;
        step_clk();
        bus.eret_i = 1'b0; bus.exc_valid_i = 1'b0;
        check("eret_exc_status", bus.status_o, 32'h0040_0003);
        check("eret_exc_epc", bus.epc_o, 32'h0000_0100);
        check("eret_exc_cause", bus.cause_o, 32'h0000_0000);

        // Hardware interrupt sampling, one cycle latency
        bus.int_i = 6'h2A;
        #1;
        check("int_before", bus.cause_o, 32'h0000_0000);
        step_clk();
        check("int_after", bus.cause_o, 32'h0000_A800);
        bus.int_i = 6'd0;
        step_clk();

        // Count wrap
        bus.we_i = 1'b1; bus.waddr_i = 5'd9; bus.wdata_i = 32'hFFFF_FFFF;
        step_clk();
        bus.we_i = 1'b0;
        check("wrap_load", bus.count_o, 32'hFFFF_FFFF);
        found = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step_clk();
            if (bus.count_o != 32'hFFFF_FFFF) begin
                found = 1'b1;
                break;
            end
        end
        check("wrap_stepped", {31'd0, found}, 32'd1);
        check("wrap_zero", bus.count_o, 32'd0);

        // Asynchronous reset mid-cycle, no clock edge
        bus.raddr_i = 5'd12;
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        check("async_rst_rdata", bus.rdata_o, 32'h0040_0000);
        #20;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file that consumes CP0 writes retired by the writeback stage (write enable, 5-bit address, 32-bit data).
- Also consumes exception/ERET commits from the MEM stage.
- Maintains Count/Compare timer, Status, Cause, EPC and BadVAddr.
- Provides a bypassed combinational read port for MFC0 in EX, plus direct register outputs for the exception/PC-redirect logic.

Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).
- COUNT_DIV, 2, Count increments once per COUNT_DIV clocks; legal values 1 or 2.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- we_i  in  1  CP0 write enable from writeback
- waddr_i  in  5  CP0 write register number
- wdata_i  in  32  CP0 write data
- raddr_i  in  5  CP0 read register number (MFC0)
- rdata_o  out  32  read data, combinational
- int_i  in  6  external hardware interrupts, level-sensitive
- exc_valid_i  in  1  exception committed this cycle
- exc_code_i  in  5  ExcCode of committed exception
- exc_pc_i  in  32  PC of faulting instruction
- exc_bd_i  in  1  faulting instruction is in a delay slot
- exc_badvaddr_i  in  32  faulting address, for AdEL/AdES
- eret_i  in  1  ERET committed this cycle
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  current register values
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.
- Asynchronous reset:
  - Status=STATUS_RST.
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - timer_int_o=0; divider tick=0.
  - All outputs reflect these values while rst is high.
- Count:
  - With COUNT_DIV=2, a 1-bit tick toggles every clock and Count+1 is applied when tick==1. Count therefore steps every 2nd clock, first step on the 2nd clock after reset release.
  - With COUNT_DIV=1, Count steps every clock.
  - Count wraps 32'hFFFF_FFFF -> 0.
  - A write to Count loads wdata_i and overrides the increment in that cycle; the tick is not reset.
- Compare/timer:
  - timer_int_o sets on the clock where Compare!=0 and Count==Compare (pre-increment value), and stays set.
  - A write to Compare loads the new value and clears timer_int_o. If set and clear coincide, clear wins.
- Status:
  - Writable bits: IM[15:8], EXL[1], IE[0]. All other bits hold their reset value.
- Cause:
  - Every clock, IP[7:2] <= {int_i[5] | timer_int_o, int_i[4:0]}, one-cycle sampling latency.
  - Only IP[1:0] is writable by software.
  - TI[30] mirrors timer_int_o.
- BadVAddr: read-only to software; writes are ignored.
- Exception commit (exc_valid_i=1):
  - Cause.ExcCode[6:2] <= exc_code_i.
  - Status.EXL <= 1.
  - If Status.EXL was 0: EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD[31] <= exc_bd_i. If EXL was already 1, EPC and BD are unchanged.
  - If exc_code_i is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badvaddr_i.
- ERET (eret_i=1, exc_valid_i=0): Status.EXL <= 0.
- Priority:
  - exc_valid_i beats eret_i; eret is ignored in that cycle.
  - Exception/ERET updates to EPC, Status.EXL, Cause.BD and Cause.ExcCode beat a same-cycle WB write to the same field.
  - Non-conflicting writable fields of the same register still take the WB write.
- Read bypass:
  - If we_i && waddr_i==raddr_i and the register is writable, rdata_o returns the value the register will hold after the write, writable-bit merge applied.
  - Otherwise rdata_o returns the stored value.
  - The read port does not bypass exception updates.

Test Plan:
1. Reset release, COUNT_DIV=2, idle 10 clocks -> Count=5. Status=32'h0040_0000. All other registers 0.
2. Write Compare=20 (Count reset to 0 just before) -> timer_int_o=1 and Cause[30]=1 after Count reaches 20. Then rewrite Compare=100 -> timer_int_o=0 next clock. A same-cycle match plus Compare write -> stays 0.
3. Write Status=32'hFFFF_FFFF -> reads 32'h0040_FF03. Write Cause=32'hFFFF_FFFF with int_i=0 -> reads 32'h0000_0300. Read the same address in the write cycle -> bypassed merged value.
4. exc_valid_i, code 4, pc 32'hBFC0_0100, bd=1, badvaddr 32'h1234_5671:
   - EPC=32'hBFC0_00FC, Cause.BD=1, ExcCode=4, EXL=1, BadVAddr=32'h1234_5671.
   - A second exception (code 8, pc 32'h8000_0000) -> EPC unchanged, ExcCode=8.
5. eret_i together with a WB write Status=32'h0000_0001 -> EXL=0, IE=1. eret_i and exc_valid_i together -> EXL=1.
6. Count=32'hFFFF_FFFF via write -> 0 after the next step. Assert rst mid-run -> every output returns to its reset value immediately, with no clock edge.
